apple_spawner: RTL and testbench

APPLE_SPAWNER -- requirements
Module: apple_spawner

---
 rtl/apple_spawner_if.sv | 31 +++
 rtl/apple_spawner.sv | 139 +++++++++++++
 tb/tb_apple_spawner.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apple_spawner_if.sv
`default_nettype none
// ============================================================================
//  Module   : apple_spawner_if
//  Brief    : Game-side bundle between the snake game logic and the apple
//             spawner: run/step control, head position in, apple out.
//  Revision : 1.0  initial release
// ============================================================================
interface apple_spawner_if;
  logic       enable;
  logic       step;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic [7:0] apple_x;
  logic [6:0] apple_y;
  logic       apple_valid;
  logic       eaten;
  logic [7:0] score;

  // Game logic side: drives control and head, consumes apple and score
  modport master (
    output enable, step, head_x, head_y,
    input  apple_x, apple_y, apple_valid, eaten, score
  );

  // Spawner side
  modport slave (
    input  enable, step, head_x, head_y,
    output apple_x, apple_y, apple_valid, eaten, score
  );
endinterface
`default_nettype wire

// File: rtl/apple_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : apple_spawner
//  Brief    : Places an apple on a random grid cell that does not overlap the
//             snake head, detects when the head eats it and keeps the score.
//  Revision : 1.0  initial release
// ============================================================================
module apple_spawner #(
  parameter int          XDIM   = 10,
  parameter int          YDIM   = 10,
  parameter int          XCELLS = 16,
  parameter int          YCELLS = 12,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic           CLOCK_50,
  input  logic           Resetn,
  apple_spawner_if.slave bus_io
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PICK  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] SHOW  = 2'd3;

  // A zero seed would lock the LFSR, so fall back to 1
  localparam logic [15:0] LFSR_INIT = (SEED == 16'd0) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [7:0] XDIM_8 = 8'(XDIM);
  localparam logic [6:0] YDIM_7 = 7'(YDIM);
  localparam logic [8:0] XDIM_9 = 9'(XDIM);
  localparam logic [7:0] YDIM_8 = 8'(YDIM);

  // Box overlap test; distances widened by one bit so they never wrap
  function automatic logic boxes_overlap(input logic [7:0] ax, input logic [6:0] ay,
                                         input logic [7:0] hx, input logic [6:0] hy);
    logic [8:0] dx;
    logic [7:0] dy;
    dx = (ax >= hx) ? ({1'b0, ax} - {1'b0, hx}) : ({1'b0, hx} - {1'b0, ax});
    dy = (ay >= hy) ? ({1'b0, ay} - {1'b0, hy}) : ({1'b0, hy} - {1'b0, ay});
    return (dx < XDIM_9) && (dy < YDIM_8);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  cx_q, cx_d;
  logic [3:0]  cy_q, cy_d;
  logic [7:0]  apple_x_q, apple_x_d;
  logic [6:0]  apple_y_q, apple_y_d;
  logic        eaten_q, eaten_d;
  logic [7:0]  score_q, score_d;

  logic [7:0]  cand_x;
  logic [6:0]  cand_y;
  logic        cand_reject;
  logic        apple_hit;

  // Candidate pixel position and acceptance, plus eat detection on the shown apple
  assign cand_x      = {4'd0, cx_q} * XDIM_8;
  assign cand_y      = {3'd0, cy_q} * YDIM_7;
  assign cand_reject = (32'(cx_q) >= XCELLS) || (32'(cy_q) >= YCELLS) ||
                       boxes_overlap(cand_x, cand_y, bus_io.head_x, bus_io.head_y);
  assign apple_hit   = boxes_overlap(apple_x_q, apple_y_q, bus_io.head_x, bus_io.head_y);

  // Galois LFSR, free-running every cycle out of reset
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // State and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_INIT;
      cx_q      <= '0;
      cy_q      <= '0;
      apple_x_q <= '0;
      apple_y_q <= '0;
      eaten_q   <= 1'b0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      eaten_q   <= eaten_d;
      score_q   <= score_d;
    end
  end

  // Next-state: retry a candidate until it is on the grid and clear of the head
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_io.enable) state_d = PICK;
      PICK:    state_d = CHECK;
      CHECK:   state_d = cand_reject ? PICK : SHOW;
      SHOW:    if (bus_io.step && apple_hit) state_d = PICK;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates per state: latch candidate, publish apple, count eats
  always_comb begin
    cx_d      = cx_q;
    cy_d      = cy_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    eaten_d   = 1'b0;
    score_d   = score_q;
    case (state_q)
      PICK: begin
        cx_d = lfsr_q[3:0];
        cy_d = lfsr_q[7:4];
      end
      CHECK: begin
        if (!cand_reject) begin
          apple_x_d = cand_x;
          apple_y_d = cand_y;
        end
      end
      SHOW: begin
        if (bus_io.step && apple_hit) begin
          eaten_d = 1'b1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus_io.apple_x     = apple_x_q;
  assign bus_io.apple_y     = apple_y_q;
  assign bus_io.apple_valid = (state_q == SHOW);
  assign bus_io.eaten       = eaten_q;
  assign bus_io.score       = score_q;

endmodule
`default_nettype wire

// File: tb/tb_apple_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apple_spawner
//  Brief    : Self-checking bench for apple_spawner with a spec-level model
//             of the LFSR-driven apple placement and the score counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apple_spawner;

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b0;

  apple_spawner_if bus ();

  apple_spawner #(
    .XDIM(10), .YDIM(10), .XCELLS(16), .YCELLS(12), .SEED(16'hACE1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .bus_io   (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_spawns = 0;
  int m_score  = 0;
  int m_ax     = 0;
  int m_ay     = 0;
  logic [15:0] m_lfsr;

  typedef struct {
    int dx;
    int dy;
    bit eat;
  } vec_t;
  vec_t vecs[11];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Model of the DUT's LFSR register contents after each edge
  always @(posedge CLOCK_50) m_lfsr <= !Resetn ? 16'hACE1 : lfsr_adv(m_lfsr);

  function automatic bit hits(input int ax, input int ay, input int hx, input int hy);
    int dx, dy;
    dx = ax - hx; if (dx < 0) dx = -dx;
    dy = ay - hy; if (dy < 0) dy = -dy;
    return (dx < 10) && (dy < 10);
  endfunction

  // Candidate k is taken from the LFSR 2k steps after the first PICK cycle
  task automatic predict(input logic [15:0] p, input int hx, input int hy,
                         output int ax, output int ay, output int k);
    logic [15:0] l;
    int cx, cy;
    l = p; k = -1; ax = 0; ay = 0;
    for (int i = 0; i < 256; i++) begin
      cx = int'(l[3:0]);
      cy = int'(l[7:4]);
      if (cy < 12 && cx < 16 && !hits(cx * 10, cy * 10, hx, hy)) begin
        ax = cx * 10; ay = cy * 10; k = i;
        return;
      end
      l = lfsr_adv(lfsr_adv(l));
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  // Called at the negedge inside a PICK cycle; follows the search to SHOW
  task automatic do_spawn(input int hx, input int hy, input bit noise);
    int eax, eay, k, lat, vbad, ebad;
    bus.head_x = 8'(hx);
    bus.head_y = 7'(hy);
    bus.step   = 1'b0;
    predict(m_lfsr, hx, hy, eax, eay, k);
    if (k < 0) begin
      n_tests++; n_fail++;
      $display("FAIL predict: no acceptable cell, got %0d expected >=0", k);
      return;
    end
    lat = 2 + 2 * k; vbad = 0; ebad = 0;
    for (int j = 1; j <= lat; j++) begin
      bus.step = noise ? 1'($urandom) : 1'b0;
      tick();
      if (bus.apple_valid !== (j == lat)) vbad++;
      if (bus.eaten !== 1'b0) ebad++;
    end
    bus.step = 1'b0;
    n_spawns++;
    chk("spawn_latency", vbad, 0);
    chk("eaten_quiet_in_spawn", ebad, 0);
    chk("apple_x", int'(bus.apple_x), eax);
    chk("apple_y", int'(bus.apple_y), eay);
    chk("apple_x_grid", int'(bus.apple_x) % 10, 0);
    chk("apple_y_grid", int'(bus.apple_y) % 10, 0);
    chk("apple_x_range", int'(bus.apple_x) <= 150, 1);
    chk("apple_y_range", int'(bus.apple_y) <= 110, 1);
    chk("apple_clear_of_head", hits(int'(bus.apple_x), int'(bus.apple_y), hx, hy), 0);
    chk("score_hold", int'(bus.score), m_score);
    m_ax = eax; m_ay = eay;
  endtask

  // Called at a negedge in SHOW; one step pulse with the head at (hx,hy)
  task automatic do_step(input int hx, input int hy, input bit exp_eat);
    bus.head_x = 8'(hx);
    bus.head_y = 7'(hy);
    bus.step   = 1'b1;
    tick();
    bus.step   = 1'b0;
    if (exp_eat && m_score < 255) m_score++;
    chk("eaten_pulse", int'(bus.eaten), int'(exp_eat));
    chk("score", int'(bus.score), m_score);
    chk("apple_valid_after_step", int'(bus.apple_valid), int'(!exp_eat));
    if (!exp_eat) begin
      chk("apple_x_stable", int'(bus.apple_x), m_ax);
      chk("apple_y_stable", int'(bus.apple_y), m_ay);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_apple_valid"}, int'(bus.apple_valid), 0);
    chk({tag, "_apple_x"}, int'(bus.apple_x), 0);
    chk({tag, "_apple_y"}, int'(bus.apple_y), 0);
    chk({tag, "_eaten"}, int'(bus.eaten), 0);
    chk({tag, "_score"}, int'(bus.score), 0);
  endtask

  task automatic idle_hold(input string tag);
    int bad;
    bus.enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.apple_valid !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
  endtask

  initial begin
    int hx, hy;
    bit e;
    vecs[0]  = '{dx: 10,  dy: 0,   eat: 1'b0};
    vecs[1]  = '{dx: 0,   dy: 10,  eat: 1'b0};
    vecs[2]  = '{dx: 10,  dy: 10,  eat: 1'b0};
    vecs[3]  = '{dx: -10, dy: 0,   eat: 1'b0};
    vecs[4]  = '{dx: 0,   dy: -10, eat: 1'b0};
    vecs[5]  = '{dx: -10, dy: -9,  eat: 1'b0};
    vecs[6]  = '{dx: 9,   dy: 9,   eat: 1'b1};
    vecs[7]  = '{dx: -9,  dy: 0,   eat: 1'b1};
    vecs[8]  = '{dx: 0,   dy: -9,  eat: 1'b1};
    vecs[9]  = '{dx: 9,   dy: -9,  eat: 1'b1};
    vecs[10] = '{dx: 0,   dy: 0,   eat: 1'b1};

    bus.enable = 1'b0; bus.step = 1'b0; bus.head_x = '0; bus.head_y = '0;
    Resetn = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    Resetn = 1'b1;

    // Held idle with enable low, then started with head at the origin
    idle_hold("idle_while_disabled");
    do_spawn(0, 0, 1'b0);
    do_step(m_ax, m_ay, 1'b1);
    do_spawn(0, 0, 1'b0);

    // Table of head offsets relative to the shown apple
    for (int i = 0; i < 11; i++) begin
      hx = m_ax + vecs[i].dx;
      hy = m_ay + vecs[i].dy;
      if (hx < 0 || hx > 255 || hy < 0 || hy > 127) continue;
      do_step(hx, hy, vecs[i].eat);
      if (vecs[i].eat) do_spawn($urandom_range(0, 255), $urandom_range(0, 127), 1'b0);
    end

    // Reset while the candidate is being checked
    do_step(m_ax, m_ay, 1'b1);
    tick();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    m_score = 0;
    chk_reset_outputs("reset_in_check");
    idle_hold("idle_after_check_reset");
    do_spawn($urandom_range(0, 255), $urandom_range(0, 127), 1'b0);

    // Reset on the same edge as an eat: the eat must be discarded
    do_step(m_ax, m_ay, 1'b1);
    do_spawn($urandom_range(0, 255), $urandom_range(0, 127), 1'b0);
    bus.head_x = 8'(m_ax); bus.head_y = 7'(m_ay); bus.step = 1'b1;
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1; bus.step = 1'b0;
    m_score = 0;
    chk_reset_outputs("reset_in_show");
    idle_hold("idle_after_show_reset");
    do_spawn($urandom_range(0, 255), $urandom_range(0, 127), 1'b0);

    // Long randomized run: past score saturation, stray steps mixed in
    n_spawns = 0;
    while (n_spawns < 1000) begin
      if ($urandom_range(0, 3) == 0) begin
        hx = $urandom_range(0, 255);
        hy = $urandom_range(0, 127);
        e  = hits(m_ax, m_ay, hx, hy);
        do_step(hx, hy, e);
      end else begin
        do_step(m_ax + $urandom_range(0, 9), m_ay + $urandom_range(0, 9), 1'b1);
        e = 1'b1;
      end
      if (e) do_spawn($urandom_range(0, 255), $urandom_range(0, 127), 1'b1);
    end
    chk("score_saturated", int'(bus.score), 255);
    do_step(m_ax, m_ay, 1'b1);
    chk("score_after_extra_eat", int'(bus.score), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
